// File: rtl/floo_mcast_fork_ctrl_if.sv
// Handshake bundle between the route-select stage and the output routes.
// Signal names are given from the fork controller's point of view.
interface floo_mcast_fork_ctrl_if #(
    parameter int unsigned NumRoutes = 5,
    parameter type         flit_t    = logic
);
    logic                 valid_i;
    logic                 ready_o;
    flit_t                channel_i;
    logic [NumRoutes-1:0] route_sel_i;
    logic [NumRoutes-1:0] valid_o;
    logic [NumRoutes-1:0] ready_i;
    flit_t                channel_o;

    // Fork controller side
    modport slave (
        input  valid_i, channel_i, route_sel_i, ready_i,
        output ready_o, valid_o, channel_o
    );

    // Environment side (upstream stage plus output routes)
    modport master (
        output valid_i, channel_i, route_sel_i, ready_i,
        input  ready_o, valid_o, channel_o
    );
endinterface

// File: rtl/floo_mcast_fork_ctrl.sv
// Multicast fork handshake controller: offers one upstream flit to every
// selected output route independently and acknowledges upstream only when
// all selected routes have taken it. Also counts dropped (empty-mask) flits
// and flags/counts stalled forks.

// Protocol checker: upstream must keep the route mask stable while a flit is
// pending and must not withdraw a partially delivered flit.
module floo_mcast_fork_ctrl_chk #(
    parameter int unsigned NumRoutes = 5
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    input logic                 valid_i,
    input logic                 ready_o,
    input logic                 busy_o,
    input logic [NumRoutes-1:0] route_sel_i
);
    a_route_sel_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (valid_i && !ready_o) |=> (!valid_i || (route_sel_i == $past(route_sel_i))))
        else $error("route_sel_i changed while a fork was pending");

    a_valid_held_busy: assert property (@(posedge clk_i) disable iff (!rst_ni)
        busy_o |-> valid_i)
        else $error("valid_i dropped while fork partially delivered");
endmodule

module floo_mcast_fork_ctrl #(
    parameter int unsigned NumRoutes      = 5,
    parameter type         flit_t         = logic,
    parameter int unsigned StallThreshold = 256,
    parameter int unsigned CntWidth       = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    floo_mcast_fork_ctrl_if.slave fork_io,
    output logic                  busy_o,
    output logic                  stall_o,
    output logic [CntWidth-1:0]   drop_cnt_o,
    output logic [CntWidth-1:0]   stall_cnt_o
);
    localparam logic [CntWidth-1:0]  CntMax   = {CntWidth{1'b1}};
    localparam logic [CntWidth-1:0]  CntOne   = {{(CntWidth-1){1'b0}}, 1'b1};
    localparam logic [CntWidth-1:0]  StallThr = CntWidth'(StallThreshold);
    localparam logic [NumRoutes-1:0] RtZero   = {NumRoutes{1'b0}};

    logic [NumRoutes-1:0] sent_q, sent_d;
    logic [NumRoutes-1:0] valid_s, acc_s;
    logic                 done_s, drop_s;
    logic [CntWidth-1:0]  blk_q, blk_d;
    logic [CntWidth-1:0]  drop_q, drop_d;
    logic [CntWidth-1:0]  stall_evt_q, stall_evt_d;
    logic                 stall_q, stall_d;
    flit_t                channel_s;

    // Flit is broadcast unchanged to every route.
    assign channel_s         = fork_io.channel_i;
    assign fork_io.channel_o = channel_s;

    // Per-route offer, acceptance and full-delivery detection.
    always_comb begin
        valid_s = {NumRoutes{fork_io.valid_i}} & fork_io.route_sel_i & ~sent_q;
        acc_s   = valid_s & fork_io.ready_i;
        done_s  = fork_io.valid_i & ((fork_io.route_sel_i & ~(sent_q | acc_s)) == RtZero);
        drop_s  = done_s & (fork_io.route_sel_i == RtZero);
    end

    // Next-state for delivery tracking, blocked-cycle and event counters.
    always_comb begin
        sent_d      = sent_q;
        blk_d       = blk_q;
        drop_d      = drop_q;
        stall_evt_d = stall_evt_q;
        // A route_sel change mid-fork masks the history to the new route set.
        if (done_s) begin
            sent_d = RtZero;
        end else if (fork_io.valid_i) begin
            sent_d = (sent_q | acc_s) & fork_io.route_sel_i;
        end else begin
            sent_d = sent_q;
        end
        if (fork_io.valid_i && !done_s) begin
            blk_d = (blk_q == CntMax) ? blk_q : blk_q + CntOne;
        end else begin
            blk_d = {CntWidth{1'b0}};
        end
        if (drop_s && (drop_q != CntMax)) begin
            drop_d = drop_q + CntOne;
        end else begin
            drop_d = drop_q;
        end
        // Stall flag follows the updated blocked count so release clears it next cycle.
        stall_d = (blk_d >= StallThr);
        if (stall_d && !stall_q && (stall_evt_q != CntMax)) begin
            stall_evt_d = stall_evt_q + CntOne;
        end else begin
            stall_evt_d = stall_evt_q;
        end
    end

    // State registers; reset discards any partial delivery and clears counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sent_q      <= RtZero;
            blk_q       <= {CntWidth{1'b0}};
            drop_q      <= {CntWidth{1'b0}};
            stall_evt_q <= {CntWidth{1'b0}};
            stall_q     <= 1'b0;
        end else begin
            sent_q      <= sent_d;
            blk_q       <= blk_d;
            drop_q      <= drop_d;
            stall_evt_q <= stall_evt_d;
            stall_q     <= stall_d;
        end
    end

    assign fork_io.valid_o = valid_s;
    assign fork_io.ready_o = done_s;
    assign busy_o          = |sent_q;
    assign stall_o         = stall_q;
    assign drop_cnt_o      = drop_q;
    assign stall_cnt_o     = stall_evt_q;

    floo_mcast_fork_ctrl_chk #(
        .NumRoutes (NumRoutes)
    ) u_chk (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .valid_i     (fork_io.valid_i),
        .ready_o     (done_s),
        .busy_o      (busy_o),
        .route_sel_i (fork_io.route_sel_i)
    );
endmodule

// File: tb/tb_floo_mcast_fork_ctrl.sv
// Self-checking bench for floo_mcast_fork_ctrl: directed scenarios plus a
// randomized run compared against a per-route handshake-count model.
module tb_floo_mcast_fork_ctrl;
    localparam int NR  = 5;
    localparam int THR = 4;
    localparam int CW  = 4;
    localparam int SAT = 15;

    typedef logic [7:0] flit_t;

    logic          clk;
    logic          rst_n;
    logic          busy;
    logic          stall;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    floo_mcast_fork_ctrl_if #(.NumRoutes(NR), .flit_t(flit_t)) fork_if ();

    floo_mcast_fork_ctrl #(
        .NumRoutes      (NR),
        .flit_t         (flit_t),
        .StallThreshold (THR),
        .CntWidth       (CW)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .fork_io     (fork_if),
        .busy_o      (busy),
        .stall_o     (stall),
        .drop_cnt_o  (drop_cnt),
        .stall_cnt_o (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // m_hs[j]: handshakes route j has made for the current flit.
    int m_hs [NR];
    int m_blk;
    int m_drop;
    int m_evt;
    bit m_stall;

    function automatic logic [NR-1:0] exp_valid();
        logic [NR-1:0] r = '0;
        for (int j = 0; j < NR; j++)
            r[j] = fork_if.valid_i && fork_if.route_sel_i[j] && (m_hs[j] == 0);
        return r;
    endfunction

    function automatic bit exp_ready();
        bit r = fork_if.valid_i;
        for (int j = 0; j < NR; j++)
            if (fork_if.route_sel_i[j] && (m_hs[j] == 0) && !fork_if.ready_i[j]) r = 1'b0;
        return r;
    endfunction

    function automatic bit exp_busy();
        bit r = 1'b0;
        for (int j = 0; j < NR; j++) if (m_hs[j] > 0) r = 1'b1;
        return r;
    endfunction

    task automatic model_clear();
        for (int j = 0; j < NR; j++) m_hs[j] = 0;
        m_blk = 0; m_drop = 0; m_evt = 0; m_stall = 1'b0;
    endtask

    task automatic model_clock();
        logic [NR-1:0] ev;
        bit er;
        bit ns;
        ev = exp_valid();
        er = exp_ready();
        for (int j = 0; j < NR; j++) if (ev[j] && fork_if.ready_i[j]) m_hs[j]++;
        if (er) begin
            for (int j = 0; j < NR; j++) m_hs[j] = 0;
            m_blk = 0;
            if (fork_if.route_sel_i == '0 && m_drop < SAT) m_drop++;
        end else if (fork_if.valid_i) begin
            if (m_blk < SAT) m_blk++;
        end else begin
            m_blk = 0;
        end
        ns = (m_blk >= THR);
        if (ns && !m_stall && m_evt < SAT) m_evt++;
        m_stall = ns;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic set_in(bit v, logic [NR-1:0] sel, logic [NR-1:0] rdy, flit_t ch);
        fork_if.valid_i     = v;
        fork_if.route_sel_i = sel;
        fork_if.ready_i     = rdy;
        fork_if.channel_i   = ch;
    endtask

    task automatic step();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        set_in(1'b0, '0, '0, 8'h00);
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        checks++; if (fork_if.valid_o !== 5'b00000) begin errors++; $display("FAIL reset_valid: got %b expected 00000", fork_if.valid_o); end
        checks++; if (fork_if.ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", fork_if.ready_o); end
        checks++; if (busy !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL reset_flags: busy %b stall %b expected 0 0", busy, stall); end
        checks++; if (drop_cnt !== 4'd0 || stall_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt: drop %0d stall %0d expected 0 0", drop_cnt, stall_cnt); end
        step();
    endtask

    task automatic test_unicast();
        apply_reset();
        set_in(1'b1, 5'b00010, 5'b11111, 8'hA5);
        @(negedge clk);
        checks++; if (fork_if.valid_o !== 5'b00010) begin errors++; $display("FAIL uni_valid: got %b expected 00010", fork_if.valid_o); end
        checks++; if (fork_if.ready_o !== 1'b1) begin errors++; $display("FAIL uni_ready: got %b expected 1", fork_if.ready_o); end
        checks++; if (fork_if.channel_o !== 8'hA5) begin errors++; $display("FAIL uni_chan: got %h expected a5", fork_if.channel_o); end
        step();
        set_in(1'b0, '0, '0, 8'h00);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL uni_busy: got %b expected 0", busy); end
        step();
    endtask

    task automatic test_multicast();
        apply_reset();
        set_in(1'b1, 5'b01001, 5'b11111, 8'h3C);
        @(negedge clk);
        checks++; if (fork_if.valid_o !== 5'b01001) begin errors++; $display("FAIL mc_valid: got %b expected 01001", fork_if.valid_o); end
        checks++; if (fork_if.ready_o !== 1'b1) begin errors++; $display("FAIL mc_ready: got %b expected 1", fork_if.ready_o); end
        step();
        set_in(1'b0, '0, '0, 8'h00);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mc_busy: got %b expected 0", busy); end
        step();
    endtask

    task automatic test_partial_fork();
        int hs0 = 0;
        int hs3 = 0;
        logic [NR-1:0] rdy_seq [3] = '{5'b00001, 5'b00000, 5'b01000};
        logic [NR-1:0] exp_v   [3] = '{5'b01001, 5'b01000, 5'b01000};
        bit            exp_r   [3] = '{1'b0, 1'b0, 1'b1};
        bit            exp_b   [3] = '{1'b0, 1'b1, 1'b1};
        apply_reset();
        for (int c = 0; c < 3; c++) begin
            set_in(1'b1, 5'b01001, rdy_seq[c], 8'h77);
            @(negedge clk);
            checks++; if (fork_if.valid_o !== exp_v[c]) begin errors++; $display("FAIL part_valid c%0d: got %b expected %b", c, fork_if.valid_o, exp_v[c]); end
            checks++; if (fork_if.ready_o !== exp_r[c]) begin errors++; $display("FAIL part_ready c%0d: got %b expected %b", c, fork_if.ready_o, exp_r[c]); end
            checks++; if (busy !== exp_b[c]) begin errors++; $display("FAIL part_busy c%0d: got %b expected %b", c, busy, exp_b[c]); end
            if (fork_if.valid_o[0] && fork_if.ready_i[0]) hs0++;
            if (fork_if.valid_o[3] && fork_if.ready_i[3]) hs3++;
            step();
        end
        set_in(1'b0, '0, 5'b11111, 8'h00);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL part_busy_after: got %b expected 0", busy); end
        checks++; if (hs0 != 1 || hs3 != 1) begin errors++; $display("FAIL part_once: route0 %0d route3 %0d handshakes expected 1 1", hs0, hs3); end
        step();
    endtask

    task automatic test_empty_mask();
        apply_reset();
        for (int c = 0; c < 3; c++) begin
            set_in(1'b1, 5'b00000, 5'b11111, 8'(c));
            @(negedge clk);
            checks++; if (fork_if.ready_o !== 1'b1 || fork_if.valid_o !== 5'b00000) begin errors++; $display("FAIL empty_hs c%0d: ready %b valid %b expected 1 00000", c, fork_if.ready_o, fork_if.valid_o); end
            step();
        end
        set_in(1'b0, '0, '0, 8'h00);
        @(negedge clk);
        checks++; if (drop_cnt !== 4'd3) begin errors++; $display("FAIL empty_cnt: got %0d expected 3", drop_cnt); end
        // Keep dropping past the counter range: must saturate.
        for (int c = 0; c < 20; c++) begin
            set_in(1'b1, 5'b00000, 5'b00000, 8'h00);
            step();
        end
        set_in(1'b0, '0, '0, 8'h00);
        @(negedge clk);
        checks++; if (drop_cnt !== 4'd15) begin errors++; $display("FAIL drop_sat: got %0d expected 15", drop_cnt); end
        step();
    endtask

    task automatic test_stall();
        apply_reset();
        for (int c = 0; c < 10; c++) begin
            set_in(1'b1, 5'b00100, 5'b00000, 8'h11);
            @(negedge clk);
            checks++; if (stall !== (c >= THR)) begin errors++; $display("FAIL stall_flag c%0d: got %b expected %b", c, stall, (c >= THR)); end
            checks++; if (fork_if.ready_o !== 1'b0) begin errors++; $display("FAIL stall_ready c%0d: got %b expected 0", c, fork_if.ready_o); end
            step();
        end
        checks++; if (stall_cnt !== 4'd1) begin errors++; $display("FAIL stall_cnt: got %0d expected 1", stall_cnt); end
        set_in(1'b1, 5'b00100, 5'b00100, 8'h11);
        @(negedge clk);
        checks++; if (fork_if.ready_o !== 1'b1) begin errors++; $display("FAIL stall_release: got %b expected 1", fork_if.ready_o); end
        step();
        set_in(1'b0, '0, '0, 8'h00);
        @(negedge clk);
        checks++; if (stall !== 1'b0 || stall_cnt !== 4'd1) begin errors++; $display("FAIL stall_clear: stall %b cnt %0d expected 0 1", stall, stall_cnt); end
        step();
    endtask

    task automatic test_reset_midfork();
        apply_reset();
        set_in(1'b1, 5'b00000, 5'b00000, 8'h00);
        step();
        set_in(1'b1, 5'b01001, 5'b00001, 8'h5A);
        step();
        set_in(1'b1, 5'b01001, 5'b00000, 8'h5A);
        @(negedge clk);
        checks++; if (busy !== 1'b1 || drop_cnt !== 4'd1) begin errors++; $display("FAIL rmf_pre: busy %b drop %0d expected 1 1", busy, drop_cnt); end
        rst_n = 1'b0;
        model_clear();
        #1;
        checks++; if (busy !== 1'b0 || drop_cnt !== 4'd0 || stall_cnt !== 4'd0) begin errors++; $display("FAIL rmf_in_reset: busy %b drop %0d stall %0d expected 0 0 0", busy, drop_cnt, stall_cnt); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++; if (fork_if.valid_o !== 5'b01001) begin errors++; $display("FAIL rmf_reoffer: got %b expected 01001", fork_if.valid_o); end
        step();
        set_in(1'b1, 5'b01001, 5'b11111, 8'h5A);
        @(negedge clk);
        checks++; if (fork_if.ready_o !== 1'b1) begin errors++; $display("FAIL rmf_done: got %b expected 1", fork_if.ready_o); end
        step();
        set_in(1'b0, '0, '0, 8'h00);
        step();
    endtask

    task automatic test_random();
        bit            v = 1'b0;
        bit            in_flight = 1'b0;
        logic [NR-1:0] sel = '0;
        logic [NR-1:0] rdy;
        flit_t         ch = 8'h00;
        logic [NR-1:0] ev;
        bit            er;
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            if (!in_flight) begin
                v   = ($urandom_range(0, 3) != 0);
                sel = ($urandom_range(0, 7) == 0) ? 5'b00000 : NR'($urandom_range(0, 31));
                ch  = 8'($urandom);
            end
            if ((c % 250) < 25) rdy = 5'b00000;
            else if ($urandom_range(0, 2) == 0) rdy = 5'b11111;
            else rdy = NR'($urandom_range(0, 31));
            set_in(v, sel, rdy, ch);
            @(negedge clk);
            ev = exp_valid();
            er = exp_ready();
            checks++; if (fork_if.valid_o !== ev) begin errors++; $display("FAIL rnd_valid c%0d: got %b expected %b", c, fork_if.valid_o, ev); end
            checks++; if (fork_if.ready_o !== er) begin errors++; $display("FAIL rnd_ready c%0d: got %b expected %b", c, fork_if.ready_o, er); end
            checks++; if (busy !== exp_busy()) begin errors++; $display("FAIL rnd_busy c%0d: got %b expected %b", c, busy, exp_busy()); end
            checks++; if (stall !== m_stall) begin errors++; $display("FAIL rnd_stall c%0d: got %b expected %b", c, stall, m_stall); end
            checks++; if (drop_cnt !== CW'(m_drop)) begin errors++; $display("FAIL rnd_drop c%0d: got %0d expected %0d", c, drop_cnt, m_drop); end
            checks++; if (stall_cnt !== CW'(m_evt)) begin errors++; $display("FAIL rnd_stallcnt c%0d: got %0d expected %0d", c, stall_cnt, m_evt); end
            checks++; if (fork_if.channel_o !== ch) begin errors++; $display("FAIL rnd_chan c%0d: got %h expected %h", c, fork_if.channel_o, ch); end
            in_flight = v && !er;
            step();
        end
        set_in(1'b0, '0, '0, 8'h00);
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        model_clear();
        set_in(1'b0, '0, '0, 8'h00);
        test_reset();
        test_unicast();
        test_multicast();
        test_partial_fork();
        test_empty_mask();
        test_stall();
        test_reset_midfork();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
